// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch path.
// Provides the refill FSM state type, line/word geometry, and the word-select helper.
package mips_pkg;

  localparam int unsigned LINE_W   = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OFFSET_W = 4;

  typedef enum logic {IDLE, REFILL} state_t;

  // Pick 32-bit word `sel` out of a 128-bit line (word0 in the low bits).
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        sel);
    return line[{sel, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache.
//   slave  : view used by icache_ctrl (takes fetch request and memory data,
//            drives instruction/hit, refill request and miss count)
//   master : view used by the environment (fetch stage + instruction memory)
interface icache_ctrl_if;

  logic         req;
  logic [31:0]  pc;
  logic         flush;
  logic [31:0]  instruction;
  logic         hit;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_line;
  logic [15:0]  miss_count;

  modport slave (
    input  req, pc, flush, mem_ready, mem_line,
    output instruction, hit, mem_req, mem_addr, miss_count
  );

  modport master (
    output req, pc, flush, mem_ready, mem_line,
    input  instruction, hit, mem_req, mem_addr, miss_count
  );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for a direct-mapped instruction cache.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rd_idx              combinational read index
//   rd_valid/tag/line   contents of the indexed line
//   we, wr_idx,
//   wr_tag, wr_line     single write port; sets the line valid
//   inv_all             clears every valid bit; wins over a same-cycle write
module icache_line_store
  import mips_pkg::*;
#(
  parameter  int unsigned LINES = 16,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned TAG_W = 32 - OFFSET_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              inv_all
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LINES); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (we) begin
        tag_q[wr_idx] <= wr_tag;
      end
      if (inv_all) begin
        valid_q <= '0;
      end else if (we) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Data array carries no reset; a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with line refill over req/ready.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  icache_ctrl_if.slave: fetch req/pc/flush in, instruction/hit out;
//        mem_req/mem_addr out, mem_ready/mem_line in; miss_count out
module icache_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input logic          clk,
  input logic          rst,
  icache_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - OFFSET_W - IDX_W;

  state_t      state_q;
  logic [31:0] mem_addr_q;
  logic        mem_req_q;
  logic [15:0] miss_count_q;
  logic        flush_pending_q;

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit_c;
  logic              start_miss;
  logic              fill;
  logic              inv_all;
  logic              unused_pc_lsb;

  assign pc_idx        = bus.pc[OFFSET_W +: IDX_W];
  assign pc_tag        = bus.pc[31 -: TAG_W];
  assign unused_pc_lsb = ^bus.pc[1:0];

  assign hit_c      = (state_q == IDLE) && bus.req && rd_valid && (rd_tag == pc_tag) &&
                      !bus.flush;
  assign start_miss = (state_q == IDLE) && bus.req && !hit_c && !bus.flush;
  assign fill       = (state_q == REFILL) && bus.mem_ready;
  // A flush seen at any point of a refill also drops the line being written.
  assign inv_all    = ((state_q == IDLE) && bus.flush) ||
                      (fill && (flush_pending_q || bus.flush));

  icache_line_store #(
    .LINES (LINES)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (fill),
    .wr_idx   (mem_addr_q[OFFSET_W +: IDX_W]),
    .wr_tag   (mem_addr_q[31 -: TAG_W]),
    .wr_line  (bus.mem_line),
    .inv_all  (inv_all)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      mem_addr_q      <= '0;
      mem_req_q       <= 1'b0;
      miss_count_q    <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_miss) begin
            state_q    <= REFILL;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {bus.pc[31:OFFSET_W], {OFFSET_W{1'b0}}};
            if (miss_count_q != 16'hFFFF) begin
              miss_count_q <= miss_count_q + 16'd1;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            state_q         <= IDLE;
            mem_req_q       <= 1'b0;
            flush_pending_q <= 1'b0;
          end else if (bus.flush) begin
            flush_pending_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hit         = hit_c;
  assign bus.instruction = hit_c ? word_sel(rd_line, bus.pc[3:2]) : 32'h0;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.miss_count  = miss_count_q;

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  icache_ctrl_if bus ();

  icache_ctrl #(
    .LINES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] L1 = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
  localparam logic [127:0] L2 = {32'h00004444, 32'h00003333, 32'h00002222, 32'h00001111};
  localparam logic [127:0] L3 = {32'h80000003, 32'h80000002, 32'h80000001, 32'h80000000};
  localparam logic [127:0] L4 = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req       = 1'b0;
    bus.pc        = 32'h0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_line  = '0;

    // Reset state
    #1;
    chk("rst_hit", 32'(bus.hit), 32'h0);
    chk("rst_instr", bus.instruction, 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_miss_count", 32'(bus.miss_count), 32'h0);
    #11 rst = 1'b1;

    // mem_ready outside REFILL is ignored
    cyc();
    bus.mem_ready = 1'b1;
    bus.mem_line  = L1;
    cyc();
    bus.mem_ready = 1'b0;
    bus.req       = 1'b1;
    bus.pc        = 32'h40;
    #1;
    chk("idle_ready_ignored_req", 32'(bus.mem_req), 32'h0);
    chk("first_miss_hit", 32'(bus.hit), 32'h0);

    // Basic miss and refill of 0x40
    cyc();
    #1;
    chk("t1_mem_req", 32'(bus.mem_req), 32'h1);
    chk("t1_mem_addr", bus.mem_addr, 32'h40);
    chk("t1_refill_hit", 32'(bus.hit), 32'h0);
    chk("t1_miss_count", 32'(bus.miss_count), 32'h1);
    bus.mem_ready = 1'b1;
    bus.mem_line  = L1;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    chk("t1_hit", 32'(bus.hit), 32'h1);
    chk("t1_instr_w0", bus.instruction, 32'h0000AAAA);
    chk("t1_mem_req_drop", 32'(bus.mem_req), 32'h0);
    bus.pc = 32'h48;
    #1;
    chk("t1_hit_w2", 32'(bus.hit), 32'h1);
    chk("t1_instr_w2", bus.instruction, 32'h0000CCCC);
    chk("t1_miss_count_after", 32'(bus.miss_count), 32'h1);

    // Conflict at index 4: 0x140 evicts 0x40
    bus.pc = 32'h140;
    #1;
    chk("t2_conflict_hit", 32'(bus.hit), 32'h0);
    cyc();
    #1;
    chk("t2_mem_addr", bus.mem_addr, 32'h140);
    chk("t2_miss_count", 32'(bus.miss_count), 32'h2);
    bus.mem_ready = 1'b1;
    bus.mem_line  = L2;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    chk("t2_hit_140", 32'(bus.hit), 32'h1);
    chk("t2_instr_140", bus.instruction, 32'h00001111);
    bus.pc = 32'h40;
    #1;
    chk("t2_evicted_hit", 32'(bus.hit), 32'h0);
    cyc();
    #1;
    chk("t2_mem_addr_40", bus.mem_addr, 32'h40);
    chk("t2_miss_count_3", 32'(bus.miss_count), 32'h3);
    bus.mem_ready = 1'b1;
    bus.mem_line  = L1;
    cyc();
    bus.mem_ready = 1'b0;
    bus.pc        = 32'h4C;
    #1;
    chk("t2_refilled_instr_w3", bus.instruction, 32'h0000DDDD);

    // Slow memory: five cycles without ready, pc wandering does not move mem_addr
    bus.pc = 32'h80;
    cyc();
    for (int i = 0; i < 5; i++) begin
      bus.pc = (i == 2) ? 32'h94 : 32'h80;
      #1;
      chk("t3_wait_mem_req", 32'(bus.mem_req), 32'h1);
      chk("t3_wait_mem_addr", bus.mem_addr, 32'h80);
      chk("t3_wait_hit", 32'(bus.hit), 32'h0);
      cyc();
    end
    bus.pc        = 32'h80;
    bus.mem_ready = 1'b1;
    bus.mem_line  = L3;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    chk("t3_hit", 32'(bus.hit), 32'h1);
    chk("t3_instr", bus.instruction, 32'h80000000);
    chk("t3_miss_count", 32'(bus.miss_count), 32'h4);

    // Flush during refill
    bus.pc = 32'hC4;
    cyc();
    #1;
    chk("t4_mem_req_c1", 32'(bus.mem_req), 32'h1);
    cyc();
    bus.flush = 1'b1;
    #1;
    chk("t4_flush_hit", 32'(bus.hit), 32'h0);
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("t4_mem_req_held", 32'(bus.mem_req), 32'h1);
    bus.mem_ready = 1'b1;
    bus.mem_line  = L4;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    chk("t4_mem_req_done", 32'(bus.mem_req), 32'h0);
    chk("t4_flushed_line_hit", 32'(bus.hit), 32'h0);
    chk("t4_miss_count_5", 32'(bus.miss_count), 32'h5);
    cyc();
    #1;
    chk("t4_new_refill_req", 32'(bus.mem_req), 32'h1);
    chk("t4_new_refill_addr", bus.mem_addr, 32'hC0);
    chk("t4_miss_count_6", 32'(bus.miss_count), 32'h6);
    bus.mem_ready = 1'b1;
    bus.mem_line  = L4;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    chk("t4_hit_after", 32'(bus.hit), 32'h1);
    chk("t4_instr_w1", bus.instruction, 32'hC0000001);

    // Flush in IDLE on a resident pc
    bus.flush = 1'b1;
    #1;
    chk("t5_flush_hit", 32'(bus.hit), 32'h0);
    chk("t5_flush_instr", bus.instruction, 32'h0);
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("t5_no_refill_on_flush", 32'(bus.mem_req), 32'h0);
    chk("t5_miss_after_flush", 32'(bus.hit), 32'h0);
    chk("t5_miss_count_6", 32'(bus.miss_count), 32'h6);
    cyc();
    #1;
    chk("t5_mem_req", 32'(bus.mem_req), 32'h1);
    chk("t5_miss_count_7", 32'(bus.miss_count), 32'h7);
    bus.mem_ready = 1'b1;
    bus.mem_line  = L4;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    chk("t5_hit_after", 32'(bus.hit), 32'h1);

    // Asynchronous reset in the middle of a refill
    bus.pc = 32'h40;
    cyc();
    #1;
    chk("t6_mem_req", 32'(bus.mem_req), 32'h1);
    chk("t6_miss_count_8", 32'(bus.miss_count), 32'h8);
    rst = 1'b0;
    #1;
    chk("t6_async_mem_req", 32'(bus.mem_req), 32'h0);
    chk("t6_async_mem_addr", bus.mem_addr, 32'h0);
    chk("t6_async_miss_count", 32'(bus.miss_count), 32'h0);
    #1 rst = 1'b1;
    bus.pc = 32'hC4;
    #1;
    chk("t6_old_line_miss", 32'(bus.hit), 32'h0);
    cyc();
    #1;
    chk("t6_refill_after_reset", 32'(bus.mem_req), 32'h1);
    chk("t6_miss_count_1", 32'(bus.miss_count), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache and refill controller that sits directly upstream of the fetch stage. It serves 32-bit instructions from 128-bit (4-word) lines and raises `hit` when the fetch address is resident. On a miss it fetches the whole line from instruction memory over a req/ready handshake. Fetch stalls (holds PC, inserts no IF/ID update) while `hit` is low.

## Interface
Parameters:
- LINES, 16: number of cache lines (power of 2, ≥2); IDX_W = log2(LINES)
- TAG_W, 32-4-IDX_W: tag width (derived, not overridable)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  fetch wants an instruction at `pc`
- pc  in  32  byte address; [1:0] ignored, [3:2] word select, [3+IDX_W:4] index, [31:4+IDX_W] tag
- flush  in  1  invalidate all lines (one-cycle pulse)
- instruction  out  32  selected word; 0 when `hit`=0
- hit  out  1  `instruction` valid this cycle
- mem_req  out  1  line refill request
- mem_addr  out  32  line-aligned refill address ({pc[31:4],4'b0})
- mem_ready  in  1  memory presents `mem_line` this cycle
- mem_line  in  128  refill data; word0 in [31:0], word3 in [127:96]
- miss_count  out  16  saturating count of refills started

## Operation
- FSM states: IDLE, REFILL.
- IDLE: `hit` = req & valid[idx] & (tag[idx]==pc tag) & !flush (combinational from registered arrays). `instruction` = line[idx] word pc[3:2] when hit.
- IDLE, req & !hit & !flush: latch `mem_addr` = {pc[31:4],4'b0}; next state REFILL; miss_count += 1 (saturates at 16'hFFFF).
- REFILL: `mem_req`=1, `mem_addr` stable, `hit`=0. On edge with mem_ready=1: write mem_line, tag, valid=1 at latched index; go IDLE.
- mem_ready while not in REFILL: ignored.
- Flush in IDLE: all valid bits cleared at next edge; `hit` forced 0 during the flush cycle; no refill starts that cycle.
- Flush in REFILL: recorded in flush_pending; the refill still completes the handshake (mem_req never dropped early); at completion all valid bits are cleared, including the new line; flush_pending cleared.
- Fetch keeps `pc` stable while `hit`=0; refill uses the latched address regardless.
- Line data array is not reset; only valid, tags (to 0), FSM, counters, and outputs are reset.

## Timing
- Reset (rst=0, asynchronous): state IDLE, all valid=0, hit=0, instruction=0, mem_req=0, mem_addr=0, miss_count=0, flush_pending=0.
- Hit latency: 0 cycles (same cycle as req).
- Miss: cycle N miss seen; N+1 mem_req=1; memory asserts mem_ready at cycle N+1+k (k≥0); cycle N+2+k IDLE, hit=1 for the same pc.
- Minimum miss penalty: 2 cycles.
- mem_req rises only from IDLE and falls on the edge after mem_ready=1; it never drops without ready.
- Reset mid-REFILL aborts immediately: mem_req=0 asynchronously; memory must discard the transaction.

## Structure
- Shared package `mips_pkg`: state enum (IDLE, REFILL), LINE_W=128, WORD_W=32, OFFSET_W=4, and the word-select helper.
- One sub-module `icache_line_store`: valid/tag/data arrays with a single write port (index, tag, line, we) and a bulk-invalidate input; combinational read by index.
- The controller (FSM, address latch, flush_pending, miss counter, hit logic) stays in `icache_ctrl`.

## Test plan
- Reset, then req with pc=0x0000_0040 → hit=0; next cycle mem_req=1, mem_addr=0x0000_0040; mem_ready with mem_line={0xDDDD,0xCCCC,0xBBBB,0xAAAA} words → following cycle hit=1, instruction=0xAAAA; pc=0x48 → hit=1, instruction=0xCCCC; miss_count=1.
- Conflict: fill 0x0000_0040, then access 0x0000_0140 (same index 4, tag 0x1) → miss and refill; return to 0x40 → miss again; miss_count=3.
- Slow memory: hold mem_ready=0 for 5 cycles → mem_req and mem_addr stay constant, hit=0 throughout; completes on cycle 6.
- Flush in REFILL: flush pulse at cycle 2 of refill, then mem_ready → state IDLE, hit=0 for the same pc, a new refill starts.
- Flush in IDLE with req on a resident pc → hit=0 that cycle; next cycle miss; mem_req follows.
- Async reset asserted mid-REFILL → mem_req=0 without a clock edge; after release, previously valid pc misses; miss_count=0.
